// File: rtl/pkt_tx_if.sv
// Handshake and frame bus between a packet requester and the pkt_tx_ctrl framer.
interface pkt_tx_if;
    logic        start;
    logic [7:0]  id;
    logic [31:0] payload;
    logic        ready;
    logic        busy;
    logic [63:0] pkt_din;
    logic        pkt_rec;
    logic        pkt_flg;
    logic        done;

    modport master (
        output start, id, payload,
        input  ready, busy, pkt_din, pkt_rec, pkt_flg, done
    );

    modport slave (
        input  start, id, payload,
        output ready, busy, pkt_din, pkt_rec, pkt_flg, done
    );
endinterface

// File: rtl/pkt_tx_ctrl.sv
// Frame builder for the 64-bit packet shift register: assembles sync/id/payload/seq,
// computes a serial CRC-8 over the top 56 bits, then paces the load and shift strobes.
module pkt_tx_ctrl #(
    parameter logic [7:0] SYNC     = 8'hA5,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter int         BIT_DIV  = 4
) (
    input  logic     clk,
    input  logic     rst,
    pkt_tx_if.slave  tx
);

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  crc_q, crc_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  seq_q, seq_d;

    logic [5:0]  bit_idx;
    logic        crc_fb;
    logic [7:0]  crc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            din_q    <= '0;
            crc_q    <= '0;
            bitcnt_q <= '0;
            div_q    <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            crc_q    <= crc_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            seq_q    <= seq_d;
        end
    end

    // The CRC walks the latched frame MSB first, one bit per cycle.
    assign bit_idx  = 6'd63 - bitcnt_q;
    assign crc_fb   = crc_q[7] ^ din_q[bit_idx];
    assign crc_step = {crc_q[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        crc_d    = crc_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        seq_d    = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (tx.start) begin
                    din_d    = {SYNC, tx.id, tx.payload, seq_q, 8'h00};
                    crc_d    = 8'h00;
                    bitcnt_d = 6'd0;
                    state_d  = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_d    = crc_step;
                bitcnt_d = bitcnt_q + 6'd1;
                if (bitcnt_q == 6'd55) begin
                    din_d[7:0] = crc_step;
                    bitcnt_d   = 6'd0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                div_d    = 8'd0;
                bitcnt_d = 6'd0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Strobe fires at the start of each period; the last bit still gets a full period.
                if (div_q == DIV_LAST) begin
                    div_d    = 8'd0;
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == 6'd63) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_DONE: begin
                seq_d   = seq_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx.ready   = (state_q == ST_IDLE);
        tx.busy    = (state_q != ST_IDLE);
        tx.pkt_rec = (state_q == ST_LOAD);
        tx.pkt_flg = (state_q == ST_SHIFT) && (div_q == 8'd0);
        tx.done    = (state_q == ST_DONE);
        tx.pkt_din = din_q;
    end

endmodule
